// File: rtl/mips_pc.sv
// Program counter for the single-cycle MIPS core: registered word address plus next-PC select.
// Optional macro PC_STALL_EN makes opcode 1 hold the current address; otherwise it behaves as NEXT.
`ifndef PC_OP_NEXT
`define PC_OP_NEXT  4'd0
`define PC_OP_STALL 4'd1
`define PC_OP_J     4'd2
`define PC_OP_JR    4'd3
`define PC_OP_BZ    4'd4
`define PC_OP_BNZ   4'd5
`define PC_OP_BG    4'd6
`define PC_OP_BNG   4'd7
`endif

module mips_pc (
  input  logic        clk,
  input  logic        rest,
  input  logic        zero,
  input  logic        great,
  input  logic [15:0] im1,
  input  logic [25:0] im2,
  input  logic [3:0]  pc_op,
  input  logic [31:0] j_reg,
  output logic [31:0] rt_addr,
  output logic [31:0] addr
);

  logic        [31:0] seq_addr;
  logic        [31:0] br_addr;
  logic        [31:0] next_addr;
  logic signed [31:0] offset;

  function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Offset is relative to the current address, not the link address.
  assign offset   = sext16(im1);
  assign seq_addr = addr + 32'd1;
  assign br_addr  = addr + offset;
  assign rt_addr  = seq_addr;

  always_comb begin
    next_addr = seq_addr;
    case (pc_op)
`ifdef PC_STALL_EN
      `PC_OP_STALL: next_addr = addr;
`endif
      `PC_OP_J:   next_addr = {addr[31:26], im2};
      `PC_OP_JR:  next_addr = j_reg;
      `PC_OP_BZ:  if (zero)   next_addr = br_addr;
      `PC_OP_BNZ: if (!zero)  next_addr = br_addr;
      `PC_OP_BG:  if (great)  next_addr = br_addr;
      `PC_OP_BNG: if (!great) next_addr = br_addr;
      default:    next_addr = seq_addr;
    endcase
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) addr <= 32'd0;
    else       addr <= next_addr;
  end

endmodule

// File: tb/tb_mips_pc.sv
// Scoreboard bench for mips_pc: expected addresses queued on drive, popped after each edge.
module tb_mips_pc;

  logic        clk = 1'b0;
  logic        rest;
  logic        zero;
  logic        great;
  logic [15:0] im1;
  logic [25:0] im2;
  logic [3:0]  pc_op;
  logic [31:0] j_reg;
  logic [31:0] rt_addr;
  logic [31:0] addr;

  logic [31:0] exp_q[$];
  int          passed = 0;
  int          total  = 0;

  mips_pc dut (
    .clk(clk), .rest(rest), .zero(zero), .great(great), .im1(im1),
    .im2(im2), .pc_op(pc_op), .j_reg(j_reg), .rt_addr(rt_addr), .addr(addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input string tag, input logic [3:0] op, input logic z, input logic g,
                      input logic [15:0] i1, input logic [25:0] i2, input logic [31:0] jr,
                      input logic [31:0] exp);
    logic [31:0] e;
    pc_op = op; zero = z; great = g; im1 = i1; im2 = i2; j_reg = jr;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, addr, e);
      check({tag, "_rt"}, rt_addr, e + 32'd1);
    end
  endtask

  initial begin
    rest = 1'b0; pc_op = 4'd0; zero = 1'b0; great = 1'b0;
    im1 = 16'd0; im2 = 26'd0; j_reg = 32'd0;
    #100;
    check("reset_addr", addr, 32'd0);
    check("reset_rt", rt_addr, 32'd1);
    rest = 1'b1;

    step("next1", 4'd0, 0, 0, 16'd0, 26'd0, 32'd0, 32'd1);
    step("next2", 4'd0, 0, 0, 16'd0, 26'd0, 32'd0, 32'd2);
    step("bg_nt", 4'd6, 0, 0, 16'd20, 26'd0, 32'd0, 32'd3);
    step("bz_t", 4'd4, 1, 0, 16'd20, 26'd0, 32'd0, 32'd23);
    step("next3", 4'd0, 0, 0, 16'd0, 26'd0, 32'd0, 32'd24);

    // Asynchronous reset between edges
    #2 rest = 1'b0;
    #1;
    check("async_rst", addr, 32'd0);
    check("async_rst_rt", rt_addr, 32'd1);
    #2 rest = 1'b1;
    step("post_rst", 4'd6, 0, 1, 16'd9, 26'd0, 32'd0, 32'd9);

    step("jr5", 4'd3, 0, 0, 16'd0, 26'd0, 32'd5, 32'd5);
    step("bnz_neg", 4'd5, 0, 0, 16'hFFFA, 26'd0, 32'd0, 32'hFFFF_FFFF);
    step("wrap", 4'd0, 0, 0, 16'd0, 26'd0, 32'd0, 32'd0);
    step("jr_hi", 4'd3, 0, 0, 16'd0, 26'd0, 32'h0400_0010, 32'h0400_0010);
    step("j", 4'd2, 1, 1, 16'd0, 26'h000_0123, 32'd0, 32'h0400_0123);
    step("jr", 4'd3, 1, 1, 16'd0, 26'd0, 32'h0040_0000, 32'h0040_0000);
    step("bng_nt", 4'd7, 0, 1, 16'd100, 26'd0, 32'd0, 32'h0040_0001);
    step("bnz_nt", 4'd5, 1, 0, 16'd100, 26'd0, 32'd0, 32'h0040_0002);
    step("rsv_f", 4'hF, 1, 1, 16'd100, 26'd0, 32'd0, 32'h0040_0003);
    step("next_flags", 4'd0, 1, 1, 16'd100, 26'd0, 32'd0, 32'h0040_0004);
    step("bg_both", 4'd6, 1, 1, 16'h0010, 26'd0, 32'd0, 32'h0040_0014);
    step("bng_t", 4'd7, 1, 0, 16'hFFFF, 26'd0, 32'd0, 32'h0040_0013);
    step("bz_nt", 4'd4, 0, 1, 16'h0050, 26'd0, 32'd0, 32'h0040_0014);
    step("jr_max", 4'd3, 0, 0, 16'd0, 26'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step("bz_wrap", 4'd4, 0, 0, 16'h0005, 26'd0, 32'd0, 32'd0);

    step("jr7", 4'd3, 0, 0, 16'd0, 26'd0, 32'd7, 32'd7);
`ifdef PC_STALL_EN
    step("stall1", 4'd1, 0, 0, 16'd0, 26'd0, 32'd0, 32'd7);
    step("stall2", 4'd1, 0, 0, 16'd0, 26'd0, 32'd0, 32'd7);
    step("stall3", 4'd1, 0, 0, 16'd0, 26'd0, 32'd0, 32'd7);
`else
    step("stall1", 4'd1, 0, 0, 16'd0, 26'd0, 32'd0, 32'd8);
    step("stall2", 4'd1, 0, 0, 16'd0, 26'd0, 32'd0, 32'd9);
    step("stall3", 4'd1, 0, 0, 16'd0, 26'd0, 32'd0, 32'd10);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
